// File: rtl/cond_pkg.sv
// Shared types and the ARM condition-code evaluator for the condition queue.
package cond_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0,
        COND_NE = 4'h1,
        COND_CS = 4'h2,
        COND_CC = 4'h3,
        COND_MI = 4'h4,
        COND_PL = 4'h5,
        COND_VS = 4'h6,
        COND_VC = 4'h7,
        COND_HI = 4'h8,
        COND_LS = 4'h9,
        COND_GE = 4'hA,
        COND_LT = 4'hB,
        COND_GT = 4'hC,
        COND_LE = 4'hD,
        COND_AL = 4'hE,
        COND_NV = 4'hF
    } cond_e;

    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_V = 0;

    // Returns {ok, undef}; NV is reported as undefined and never passes.
    function automatic logic [1:0] eval_cond(input cond_e cond, input logic [3:0] flags);
        logic ok;
        logic undef;
        logic z;
        logic c;
        logic n;
        logic v;
        z     = flags[FLAG_Z];
        c     = flags[FLAG_C];
        n     = flags[FLAG_N];
        v     = flags[FLAG_V];
        ok    = 1'b0;
        undef = 1'b0;
        case (cond)
            COND_EQ: ok = z;
            COND_NE: ok = !z;
            COND_CS: ok = c;
            COND_CC: ok = !c;
            COND_MI: ok = n;
            COND_PL: ok = !n;
            COND_VS: ok = v;
            COND_VC: ok = !v;
            COND_HI: ok = c && !z;
            COND_LS: ok = !c || z;
            COND_GE: ok = (n == v);
            COND_LT: ok = (n != v);
            COND_GT: ok = !z && (n == v);
            COND_LE: ok = z || (n != v);
            COND_AL: ok = 1'b1;
            COND_NV: undef = 1'b1;
        endcase
        return {ok, undef};
    endfunction

endpackage

// File: rtl/cond_fifo.sv
// Register-based request FIFO with synchronous flush and count-based full/empty.
module cond_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_FULL);
    assign empty   = (count_q == '0);
    assign rd_data = mem_q[rd_ptr_q];
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wr_data;
                wr_ptr_d        = wr_ptr_q + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            if (do_push && !do_pop) begin
                count_d = count_q + CNT_ONE;
            end else if (do_pop && !do_push) begin
                count_d = count_q - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/cond_eval_queue.sv
// Branch condition unit: queues condition checks, owns NZCV, and returns
// tagged pass/fail results over a valid/ready handshake.
module cond_eval_queue
    import cond_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int TAG_W    = 4,
    parameter int FLAG_FWD = 1,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flag_we,
    input  logic [3:0]       flag_in,
    output logic [3:0]       flags,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_cond,
    input  logic [TAG_W-1:0] req_tag,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_ok,
    output logic             res_undef,
    output logic [TAG_W-1:0] res_tag,
    output logic [CNT_W-1:0] taken_cnt
);

    localparam int ENTRY_W = 4 + TAG_W;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    logic [3:0]       flags_q, flags_d;
    logic             res_valid_q, res_valid_d;
    logic             res_ok_q, res_ok_d;
    logic             res_undef_q, res_undef_d;
    logic [TAG_W-1:0] res_tag_q, res_tag_d;
    logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;

    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    logic               handshake;
    logic [ENTRY_W-1:0] head;
    cond_e              head_cond;
    logic [TAG_W-1:0]   head_tag;
    logic [3:0]         eval_flags;
    logic [1:0]         head_eval;

    // Ready is held low while in reset so every output reads zero then.
    assign req_ready = rst_n && !fifo_full;
    assign push      = req_valid && !fifo_full && !flush;
    assign pop       = !fifo_empty && (!res_valid_q || res_ready) && !flush;
    assign handshake = res_valid_q && res_ready && !flush;

    cond_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .push    (push),
        .pop     (pop),
        .wr_data ({req_cond, req_tag}),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign head_cond  = cond_e'(head[ENTRY_W-1 -: 4]);
    assign head_tag   = head[TAG_W-1:0];
    assign eval_flags = ((FLAG_FWD != 0) && flag_we) ? flag_in : flags_q;
    assign head_eval  = eval_cond(head_cond, eval_flags);

    // A held result keeps its payload; only a pop reloads it.
    always_comb begin
        flags_d     = flags_q;
        res_valid_d = res_valid_q;
        res_ok_d    = res_ok_q;
        res_undef_d = res_undef_q;
        res_tag_d   = res_tag_q;
        taken_cnt_d = taken_cnt_q;
        if (flag_we) begin
            flags_d = flag_in;
        end
        if (flush) begin
            res_valid_d = 1'b0;
        end else if (pop) begin
            res_valid_d = 1'b1;
            res_ok_d    = head_eval[1];
            res_undef_d = head_eval[0];
            res_tag_d   = head_tag;
        end else if (handshake) begin
            res_valid_d = 1'b0;
        end
        if (handshake && res_ok_q) begin
            taken_cnt_d = taken_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q     <= '0;
            res_valid_q <= 1'b0;
            res_ok_q    <= 1'b0;
            res_undef_q <= 1'b0;
            res_tag_q   <= '0;
            taken_cnt_q <= '0;
        end else begin
            flags_q     <= flags_d;
            res_valid_q <= res_valid_d;
            res_ok_q    <= res_ok_d;
            res_undef_q <= res_undef_d;
            res_tag_q   <= res_tag_d;
            taken_cnt_q <= taken_cnt_d;
        end
    end

    assign flags     = flags_q;
    assign res_valid = res_valid_q;
    assign res_ok    = res_ok_q;
    assign res_undef = res_undef_q;
    assign res_tag   = res_tag_q;
    assign taken_cnt = taken_cnt_q;

endmodule

// File: tb/tb_cond_eval_queue.sv
// Scoreboard bench for cond_eval_queue: a queue-based reference model predicts
// results at evaluation time and a monitor compares them when the DUT presents them.
module tb_cond_eval_queue;

    localparam int DEPTH    = 4;
    localparam int TAG_W    = 4;
    localparam int FLAG_FWD = 1;
    localparam int CNT_W    = 4;

    logic             clk;
    logic             rst_n;
    logic             flag_we;
    logic [3:0]       flag_in;
    logic [3:0]       flags;
    logic             flush;
    logic             req_valid;
    logic             req_ready;
    logic [3:0]       req_cond;
    logic [TAG_W-1:0] req_tag;
    logic             res_valid;
    logic             res_ready;
    logic             res_ok;
    logic             res_undef;
    logic [TAG_W-1:0] res_tag;
    logic [CNT_W-1:0] taken_cnt;

    int checks = 0;
    int errors = 0;
    int accepted;

    typedef struct {
        logic [3:0]       cond;
        logic [TAG_W-1:0] tag;
    } req_t;

    typedef struct {
        logic             ok;
        logic             undef;
        logic [TAG_W-1:0] tag;
    } res_t;

    req_t       m_fifo[$];
    res_t       exp_q[$];
    logic [3:0] m_flags;
    bit         m_rv;
    bit         m_ok;
    int         m_taken;

    cond_eval_queue #(
        .DEPTH    (DEPTH),
        .TAG_W    (TAG_W),
        .FLAG_FWD (FLAG_FWD),
        .CNT_W    (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flag_we   (flag_we),
        .flag_in   (flag_in),
        .flags     (flags),
        .flush     (flush),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_cond  (req_cond),
        .req_tag   (req_tag),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_ok    (res_ok),
        .res_undef (res_undef),
        .res_tag   (res_tag),
        .taken_cnt (taken_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Flags are [Z,C,N,V]; returns {ok, undef}.
    function automatic logic [1:0] ref_eval(input logic [3:0] cond, input logic [3:0] f);
        bit z;
        bit c;
        bit n;
        bit v;
        bit pass;
        z    = f[3];
        c    = f[2];
        n    = f[1];
        v    = f[0];
        pass = 1'b0;
        if (cond == 4'd15) return 2'b01;
        case (cond)
            4'd0:  pass = z;
            4'd1:  pass = !z;
            4'd2:  pass = c;
            4'd3:  pass = !c;
            4'd4:  pass = n;
            4'd5:  pass = !n;
            4'd6:  pass = v;
            4'd7:  pass = !v;
            4'd8:  pass = c && !z;
            4'd9:  pass = !c || z;
            4'd10: pass = (n == v);
            4'd11: pass = (n != v);
            4'd12: pass = !z && (n == v);
            4'd13: pass = z || (n != v);
            default: pass = 1'b1;
        endcase
        return {pass, 1'b0};
    endfunction

    task automatic check_output(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply_stimulus(input logic rv, input logic [3:0] cond, input logic [TAG_W-1:0] tag,
                                  input logic rr, input logic fwe, input logic [3:0] fin, input logic fl);
        @(negedge clk);
        req_valid = rv;
        req_cond  = cond;
        req_tag   = tag;
        res_ready = rr;
        flag_we   = fwe;
        flag_in   = fin;
        flush     = fl;
    endtask

    // Reference model: advances once per clock edge from the stable inputs.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_fifo.delete();
            exp_q.delete();
            m_flags = 4'd0;
            m_rv    = 1'b0;
            m_ok    = 1'b0;
            m_taken = 0;
        end else begin : model_step
            bit         do_push;
            bit         do_pop;
            bit         hs;
            logic [3:0] ef;
            logic [1:0] oe;
            req_t       r;
            res_t       e;
            do_push = req_valid && (m_fifo.size() < DEPTH) && !flush;
            do_pop  = (m_fifo.size() > 0) && (!m_rv || res_ready) && !flush;
            hs      = m_rv && res_ready && !flush;
            ef      = (FLAG_FWD != 0 && flag_we) ? flag_in : m_flags;
            if (flush) begin
                m_fifo.delete();
                exp_q.delete();
                m_rv = 1'b0;
            end else begin
                if (hs && m_ok) m_taken = (m_taken + 1) % (1 << CNT_W);
                if (do_pop) begin
                    r       = m_fifo.pop_front();
                    oe      = ref_eval(r.cond, ef);
                    e.ok    = oe[1];
                    e.undef = oe[0];
                    e.tag   = r.tag;
                    exp_q.push_back(e);
                    m_rv = 1'b1;
                    m_ok = oe[1];
                end else if (hs) begin
                    m_rv = 1'b0;
                end
                if (do_push) begin
                    r.cond = req_cond;
                    r.tag  = req_tag;
                    m_fifo.push_back(r);
                end
            end
            if (flag_we) m_flags = flag_in;
        end
    end

    // Monitor: samples just before each rising edge, once inputs have settled.
    initial begin
        res_t e;
        forever begin
            @(negedge clk);
            #4;
            if (rst_n) begin
                check_output("res_valid", int'(res_valid), int'(m_rv));
                check_output("req_ready", int'(req_ready), int'(m_fifo.size() < DEPTH));
                check_output("flags", int'(flags), int'(m_flags));
                check_output("taken_cnt", int'(taken_cnt), m_taken);
                if (res_valid) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_result: got tag %0d expected no result at %0t",
                                 res_tag, $time);
                    end else begin
                        e = exp_q[0];
                        check_output("res_ok", int'(res_ok), int'(e.ok));
                        check_output("res_undef", int'(res_undef), int'(e.undef));
                        check_output("res_tag", int'(res_tag), int'(e.tag));
                        if (res_ready && !flush) void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_cond  = 4'd0;
        req_tag   = '0;
        res_ready = 1'b0;
        flag_we   = 1'b0;
        flag_in   = 4'd0;
        flush     = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Reset mid-stream with requests queued.
        apply_stimulus(1'b1, 4'd14, 4'd1, 1'b0, 1'b1, 4'b1111, 1'b0);
        apply_stimulus(1'b1, 4'd14, 4'd2, 1'b0, 1'b0, 4'd0, 1'b0);
        apply_stimulus(1'b1, 4'd14, 4'd3, 1'b0, 1'b0, 4'd0, 1'b0);
        apply_stimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_output("rst_res_valid", int'(res_valid), 0);
        check_output("rst_res_ok", int'(res_ok), 0);
        check_output("rst_res_undef", int'(res_undef), 0);
        check_output("rst_res_tag", int'(res_tag), 0);
        check_output("rst_flags", int'(flags), 0);
        check_output("rst_taken_cnt", int'(taken_cnt), 0);
        check_output("rst_req_ready", int'(req_ready), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_output("post_rst_req_ready", int'(req_ready), 1);

        // EQ then NE with Z set.
        apply_stimulus(1'b0, 4'd0, 4'd0, 1'b1, 1'b1, 4'b1000, 1'b0);
        apply_stimulus(1'b1, 4'd0, 4'd1, 1'b1, 1'b0, 4'd0, 1'b0);
        apply_stimulus(1'b1, 4'd1, 4'd2, 1'b1, 1'b0, 4'd0, 1'b0);
        repeat (3) apply_stimulus(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0);

        // GT with forwarded flags on the pop cycle.
        apply_stimulus(1'b0, 4'd0, 4'd0, 1'b1, 1'b1, 4'd0, 1'b0);
        apply_stimulus(1'b1, 4'd12, 4'd3, 1'b1, 1'b0, 4'd0, 1'b0);
        apply_stimulus(1'b0, 4'd0, 4'd0, 1'b1, 1'b1, 4'b0011, 1'b0);
        apply_stimulus(1'b0, 4'd0, 4'd0, 1'b1, 1'b1, 4'd0, 1'b0);
        apply_stimulus(1'b1, 4'd12, 4'd4, 1'b1, 1'b0, 4'd0, 1'b0);
        apply_stimulus(1'b0, 4'd0, 4'd0, 1'b1, 1'b1, 4'b0010, 1'b0);
        repeat (2) apply_stimulus(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0);

        // Fill against a stalled consumer, then drain in order.
        accepted = 0;
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(1'b1, 4'd14, TAG_W'(i + 8), 1'b0, 1'b0, 4'd0, 1'b0);
            #1;
            if (req_ready) accepted++;
        end
        apply_stimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
        #1;
        check_output("full_req_ready", int'(req_ready), 0);
        check_output("accepted_count", accepted, 5);
        repeat (7) apply_stimulus(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0);

        // NV then AL.
        apply_stimulus(1'b1, 4'd15, 4'd5, 1'b1, 1'b0, 4'd0, 1'b0);
        apply_stimulus(1'b1, 4'd14, 4'd6, 1'b1, 1'b0, 4'd0, 1'b0);
        repeat (3) apply_stimulus(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0);

        // Flush colliding with a push and a result handshake.
        apply_stimulus(1'b1, 4'd14, 4'd7, 1'b0, 1'b0, 4'd0, 1'b0);
        apply_stimulus(1'b1, 4'd14, 4'd8, 1'b0, 1'b0, 4'd0, 1'b0);
        apply_stimulus(1'b1, 4'd14, 4'd9, 1'b1, 1'b0, 4'd0, 1'b1);
        apply_stimulus(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0);
        #1;
        check_output("flush_res_valid", int'(res_valid), 0);
        repeat (2) apply_stimulus(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            apply_stimulus(1'($urandom_range(0, 1)),
                           4'($urandom_range(0, 15)),
                           TAG_W'($urandom_range(0, (1 << TAG_W) - 1)),
                           1'($urandom_range(0, 9) < 7),
                           1'($urandom_range(0, 2) == 0),
                           4'($urandom_range(0, 15)),
                           1'($urandom_range(0, 24) == 0));
        end
        repeat (8) apply_stimulus(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
